// File: rtl/ring_fifo.sv
// Parametrised synchronous ring FIFO with request/done handshakes, occupancy
// count, almost-full/empty thresholds, flush and a sticky overflow flag.
`ifndef LEN_RING_BUF_ADDR
`define LEN_RING_BUF_ADDR 4
`endif

module ring_fifo #(
  parameter int WIDTH    = 8,
  parameter int LEN_ADDR = `LEN_RING_BUF_ADDR,
  parameter int AF_LEVEL = (2**LEN_ADDR) - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                flush,
  input  logic                push,
  input  logic [WIDTH-1:0]    push_data,
  output logic                push_done,
  input  logic                pop,
  output logic [WIDTH-1:0]    pop_data,
  output logic                pop_done,
  output logic [LEN_ADDR:0]   count,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic                overflow
);

  localparam int DEPTH = 2**LEN_ADDR;
  localparam logic [LEN_ADDR:0] DEPTH_C = (LEN_ADDR+1)'(DEPTH);
  localparam logic [LEN_ADDR:0] AF_C    = (LEN_ADDR+1)'(AF_LEVEL);
  localparam logic [LEN_ADDR:0] AE_C    = (LEN_ADDR+1)'(AE_LEVEL);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [LEN_ADDR-1:0] wr_ptr;
  logic [LEN_ADDR-1:0] rd_ptr;
  logic                wr_en;

  // Flags come from the count register only, so every slot is usable.
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // A full FIFO still accepts a write when a pop frees the head slot this cycle.
  assign wr_en = rstn && !flush && push && (pop || !full);

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pop_data  <= '0;
      push_done <= 1'b0;
      pop_done  <= 1'b0;
      overflow  <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      push_done <= 1'b0;
      pop_done  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      push_done <= 1'b0;
      pop_done  <= 1'b0;
      if (push && pop) begin
        // Empty bypass forwards the incoming word; otherwise the old head leaves.
        pop_data  <= empty ? push_data : mem[rd_ptr];
        wr_ptr    <= wr_ptr + 1'b1;
        rd_ptr    <= rd_ptr + 1'b1;
        push_done <= 1'b1;
        pop_done  <= 1'b1;
      end else if (push) begin
        if (!full) begin
          wr_ptr    <= wr_ptr + 1'b1;
          count     <= count + 1'b1;
          push_done <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (pop) begin
        if (!empty) begin
          pop_data <= mem[rd_ptr];
          rd_ptr   <= rd_ptr + 1'b1;
          count    <= count - 1'b1;
          pop_done <= 1'b1;
        end
      end
    end
  end

endmodule
